// File: rtl/fetch_line_buffer.sv
// Instruction-fetch front end: holds one memory line, refills it on a miss through a
// req/valid handshake, and follows EX redirects, including ones that arrive mid-refill.
module fetch_line_buffer #(
  parameter int XLEN       = 32,
  parameter int PC_BITS    = 5,
  parameter int LINE_WORDS = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      redirect_valid,
  input  logic [PC_BITS-1:0]                        redirect_pc,
  input  logic                                      stall_in,
  output logic                                      mem_req,
  output logic [PC_BITS-$clog2(LINE_WORDS)-1:0]     mem_line_addr,
  input  logic                                      mem_valid,
  input  logic [XLEN*LINE_WORDS-1:0]                mem_line,
  output logic                                      inst_valid,
  output logic [XLEN-1:0]                           inst,
  output logic [PC_BITS-1:0]                        pc,
  output logic                                      fetch_stall
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = PC_BITS - OFF_W;

  // A request stays up from S_REQ through S_WAIT until the line arrives; the line is
  // written on the mem_valid edge so the very next cycle is back in S_IDLE and can hit.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                             state_q;
  logic [PC_BITS-1:0]                 pc_q;
  logic [IDX_W-1:0]                   tag_q, req_idx_q;
  logic                               buf_vld_q, drop_q;
  logic [LINE_WORDS-1:0][XLEN-1:0]    line_q;

  logic [IDX_W-1:0] pc_idx, rd_idx;
  logic [OFF_W-1:0] pc_off;
  logic             hit;

  assign pc_idx = pc_q[PC_BITS-1:OFF_W];
  assign pc_off = pc_q[OFF_W-1:0];
  assign rd_idx = redirect_pc[PC_BITS-1:OFF_W];
  assign hit    = buf_vld_q && (tag_q == pc_idx);

  assign inst_valid    = hit && (state_q == S_IDLE);
  assign inst          = line_q[pc_off];
  assign pc            = pc_q;
  assign fetch_stall   = rst && !inst_valid;
  assign mem_req       = (state_q != S_IDLE);
  assign mem_line_addr = req_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      tag_q     <= '0;
      req_idx_q <= '0;
      buf_vld_q <= 1'b0;
      drop_q    <= 1'b0;
      line_q    <= '0;
    end else begin
      if (redirect_valid)
        pc_q <= redirect_pc;
      else if (inst_valid && !stall_in)
        pc_q <= pc_q + PC_BITS'(1);

      case (state_q)
        S_IDLE: begin
          // A redirect moves pc away, so the miss is re-evaluated next cycle on the target.
          if (!hit && !redirect_valid) begin
            state_q   <= S_REQ;
            req_idx_q <= pc_idx;
            drop_q    <= 1'b0;
          end
        end
        S_REQ, S_WAIT: begin
          if (mem_valid) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            if (!drop_q) begin
              line_q    <= mem_line;
              tag_q     <= req_idx_q;
              buf_vld_q <= 1'b1;
            end
          end else begin
            state_q <= S_WAIT;
            // Only the latest redirect matters: returning to the requested line revives the fill.
            if (redirect_valid)
              drop_q <= (rd_idx != req_idx_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: directed scenarios plus randomized redirects/stalls/latency,
// checked against an architectural model of the fetched instruction stream.
module tb_fetch_line_buffer;
  logic         clk = 0, rst = 0;
  logic         redirect_valid = 0, stall_in = 0, mem_valid = 0;
  logic [4:0]   redirect_pc = '0;
  logic [127:0] mem_line = '0;
  logic         mem_req, inst_valid, fetch_stall;
  logic [2:0]   mem_line_addr;
  logic [31:0]  inst;
  logic [4:0]   pc;

  fetch_line_buffer #(.XLEN(32), .PC_BITS(5), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_in(stall_in), .mem_req(mem_req), .mem_line_addr(mem_line_addr),
    .mem_valid(mem_valid), .mem_line(mem_line), .inst_valid(inst_valid), .inst(inst),
    .pc(pc), .fetch_stall(fetch_stall));

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] pc; logic [31:0] inst; } exp_t;

  int          checks = 0, errors = 0;
  logic [31:0] img [32];
  exp_t        exp_q [$];
  exp_t        e;
  bit          mon_en = 0, resp_en = 0, stray_en = 0, busy = 0;
  int          lat_fix = 2, cnt = 0;
  bit          b_valid = 0, post_fill = 0, prev_req = 0;
  int          b_line = 0, bubble = 0;
  logic [2:0]  prev_addr = '0;
  logic [31:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++; errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  function automatic exp_t mk(input int p);
    exp_t r;
    r.pc   = 5'(p % 32);
    r.inst = img[p % 32];
    return r;
  endfunction

  function automatic logic [127:0] line_of(input logic [2:0] l);
    return {img[l*4+3], img[l*4+2], img[l*4+1], img[l*4]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(mk(0));
    b_valid = 0; post_fill = 0; prev_req = 0; bubble = 0;
  endtask

  // Memory: answers each request after a fixed or random latency; optionally emits stray pulses.
  initial forever begin
    @(posedge clk); #1;
    mem_valid = 0;
    if (resp_en && rst) begin
      if (busy) begin
        cnt--;
        if (cnt <= 0) begin mem_valid = 1; mem_line = line_of(mem_line_addr); busy = 0; end
      end else if (mem_req) begin
        busy = 1;
        cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        if (cnt == 0) begin mem_valid = 1; mem_line = line_of(mem_line_addr); busy = 0; end
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        mem_valid = 1;
        mem_line  = {$urandom, $urandom, $urandom, $urandom};
      end
    end else busy = 0;
  end

  // Monitor: compares what the DUT presents against the expected fetch stream and buffer contents.
  always @(negedge clk) if (mon_en && rst) begin
    e = exp_q[0];
    chk("fetch_stall", fetch_stall, !inst_valid);
    chk("pc", pc, e.pc);
    if (inst_valid) chk("inst", inst, e.inst);
    if (post_fill) begin
      chk("fill_latency", inst_valid, b_valid && (b_line == int'(e.pc / 4)));
      chk("req_drop", mem_req, 0);
    end
    if (mem_req) begin
      if (prev_req) chk("addr_hold", mem_line_addr, prev_addr);
      else begin
        chk("req_addr", mem_line_addr, e.pc / 4);
        chk("req_on_miss", b_valid && (b_line == int'(e.pc / 4)), 0);
      end
    end
    bubble = inst_valid ? 0 : bubble + 1;
    if (bubble == 200) timeout("watchdog_no_progress");
    post_fill = mem_valid && mem_req;
    // A response is kept only if pc still lies in the requested line.
    if (post_fill && (int'(e.pc / 4) == int'(mem_line_addr))) begin
      b_valid = 1; b_line = int'(mem_line_addr);
    end
    prev_req  = mem_req && !mem_valid;
    prev_addr = mem_line_addr;
    if (redirect_valid) begin
      exp_q.delete();
      exp_q.push_back(mk(int'(redirect_pc)));
    end else if (inst_valid && !stall_in) begin
      void'(exp_q.pop_front());
      exp_q.push_back(mk(int'(e.pc) + 1));
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic redirect(input int p);
    redirect_valid = 1; redirect_pc = 5'(p);
    step();
    redirect_valid = 0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (inst_valid) return;
      step();
    end
    timeout(name);
  endtask

  task automatic wait_req(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (mem_req) return;
      step();
    end
    timeout(name);
  endtask

  task automatic wait_pc(input int p, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (inst_valid && pc == 5'(p)) return;
      step();
    end
    timeout(name);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) img[i] = $urandom;
    img[0] = 32'h00000013; img[1] = 32'h00100093; img[2] = 32'h00200113; img[3] = 32'h00300193;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_fetch_stall", fetch_stall, 0);
    chk("rst_pc", pc, 0);

    // Cold start, memory latency 2
    lat_fix = 2; resp_en = 1; mon_en = 1;
    @(posedge clk); #1; rst = 1;
    @(negedge clk); chk("cold_req_c0", mem_req, 0);
    @(negedge clk); chk("cold_req_c1", mem_req, 1); chk("cold_addr", mem_line_addr, 0);
    step();
    wait_valid(10, "cold_first_valid");
    for (int k = 0; k < 2; k++) begin
      chk("cold_seq_valid", inst_valid, 1);
      chk("cold_seq_pc", pc, k);
      step();
    end

    // Stall hold at pc=2
    stall_in = 1; held = inst;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_pc", pc, 2);
      chk("stall_inst", inst, held);
      chk("stall_valid", inst_valid, 1);
      chk("stall_no_req", mem_req, 0);
      step();
    end
    stall_in = 0;
    step();
    chk("pc_after_stall", pc, 3);

    // Redirect on hit
    redirect(1);
    chk("redir_hit_pc", pc, 1);
    chk("redir_hit_valid", inst_valid, 1);
    chk("redir_hit_inst", inst, img[1]);
    chk("redir_hit_no_req", mem_req, 0);

    // Line crossing 3 -> 4
    wait_pc(4, 20, "line_cross");
    chk("line1_word0", inst, img[4]);

    // Redirect to line 4 while the line-2 request is outstanding
    lat_fix = 3;
    redirect(8);
    wait_req(5, "line2_req");
    chk("line2_addr", mem_line_addr, 2);
    step();
    redirect(17);
    wait_valid(20, "after_drop_valid");
    chk("drop_pc", pc, 17);
    chk("drop_inst", inst, img[17]);

    // Randomized traffic
    lat_fix = -1; stray_en = 1;
    repeat (3000) begin
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 5'($urandom);
      stall_in       = ($urandom_range(0, 3) == 0);
      step();
    end
    redirect_valid = 0; stall_in = 0; stray_en = 0;
    step();

    // Wrap 31 -> 0, then reset while the line-0 request is pending
    lat_fix = 3;
    wait_valid(30, "pre_wrap_valid");
    redirect(28);
    wait_pc(31, 30, "reach_31");
    step();
    chk("wrap_pc", pc, 0);
    wait_req(5, "wrap_req");
    chk("wrap_addr", mem_line_addr, 0);
    mon_en = 0; resp_en = 0; rst = 0;
    #1;
    chk("midreq_rst_req", mem_req, 0);
    chk("midreq_rst_pc", pc, 0);
    chk("midreq_rst_valid", inst_valid, 0);
    chk("midreq_rst_stall", fetch_stall, 0);
    step();
    mem_valid = 1; mem_line = {4{32'hdeadbeef}};
    step();
    mem_valid = 0; rst = 1; model_reset(); mon_en = 1;
    mem_valid = 1; mem_line = {4{32'hbadc0ffe}};
    step();
    mem_valid = 0;
    chk("stray_ignored_valid", inst_valid, 0);
    chk("stray_ignored_req", mem_req, 1);
    lat_fix = 0; resp_en = 1;
    wait_valid(10, "post_reset_valid");
    chk("post_reset_pc", pc, 0);
    chk("post_reset_inst", inst, img[0]);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
